uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_buf_if.sv | 47 ++++
 rtl/uart_tx_fifo.sv | 84 ++++++++
 rtl/uart_tx_buf.sv | 118 +++++++++++
 tb/tb_uart_tx_buf.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit front end.
// Holds the sequencer state encoding, the default FIFO depth and busy
// timeout, and a helper that sizes the occupancy counter.
package uart_pkg;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_BUSY_TO = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    // The occupancy counter must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Bundle of the write-side and transmitter-side signals of uart_tx_buf.
//   slave  : view taken by uart_tx_buf (accepts bytes, drives the UART)
//   master : view taken by whatever writes bytes and models the UART
// Signals: wr_en/wr_data (byte write), fifo_full/fifo_empty/fifo_cnt
// (occupancy), uart_en/uart_din (send request + byte), uart_tx_busy
// (transmitter busy), tx_err (dropped-byte pulse).
interface uart_tx_buf_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) ();

    logic                          wr_en;
    logic [7:0]                    wr_data;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [cnt_width(DEPTH)-1:0]   fifo_cnt;
    logic                          uart_en;
    logic [7:0]                    uart_din;
    logic                          uart_tx_busy;
    logic                          tx_err;

    modport slave (
        input  wr_en,
        input  wr_data,
        input  uart_tx_busy,
        output fifo_full,
        output fifo_empty,
        output fifo_cnt,
        output uart_en,
        output uart_din,
        output tx_err
    );

    modport master (
        output wr_en,
        output wr_data,
        output uart_tx_busy,
        input  fifo_full,
        input  fifo_empty,
        input  fifo_cnt,
        input  uart_en,
        input  uart_din,
        input  tx_err
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with registered read port for the UART transmit buffer.
// Ports:
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   wr_en, wr_data   : write strobe and byte
//   rd_en            : pop the head byte into rd_data (ignored when empty)
//   rd_data          : registered head byte, updated only on a pop
//   full, empty, cnt : registered occupancy, valid the cycle after a change
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [7:0]    mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [7:0]    rd_data_q;
    logic          wr_acc;
    logic          rd_acc;

    always_comb begin
        rd_acc = rd_en && !empty_q;
        // A pop in the same cycle frees a slot, so a full FIFO still
        // takes the write; the read sees the old head before it is replaced.
        wr_acc = wr_en && (!full_q || rd_acc);

        // Pointer width equals log2(DEPTH), so they wrap on their own.
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(wr_acc) - CW'(rd_acc);
        full_d   = (cnt_d == CW'(DEPTH));
        empty_d  = (cnt_d == '0);
    end

    // Storage: no reset so it maps onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign rd_data = rd_data_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign cnt     = cnt_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered front end for a UART transmitter. Bytes written through the
// bus are queued in uart_tx_fifo and handed to the transmitter one at a
// time: each byte gets its own uart_en rising edge, and the byte is
// dropped with a one-cycle tx_err pulse if the transmitter never reports
// busy within BUSY_TO cycles of the request.
// Ports:
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   bus (slave)      : write side, occupancy flags and transmitter handshake
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int BUSY_TO = DEF_BUSY_TO
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    uart_tx_buf_if.slave bus
);

    localparam int TW = $clog2(BUSY_TO + 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [TW-1:0] tmo_inc;
    logic          uart_en_q, uart_en_d;
    logic          tx_err_q, tx_err_d;
    logic          pop;

    logic [7:0]                  fifo_rd_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [cnt_width(DEPTH)-1:0] fifo_cnt;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .cnt     (fifo_cnt)
    );

    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        tx_err_d = 1'b0;
        pop      = 1'b0;
        tmo_inc  = tmo_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // Only launch when the transmitter is free, so a byte is
                // never requested while a previous one is still going out.
                if (!fifo_empty && !bus.uart_tx_busy) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Counter holds cycles elapsed since the START cycle.
                tmo_d   = TW'(1);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.uart_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_inc == TW'(BUSY_TO)) begin
                    tx_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered request: high exactly while the sequencer sits in
        // START or WAIT_BUSY. Every path back to a new START goes through
        // IDLE, which guarantees a low cycle between bytes.
        uart_en_d = (state_d == ST_START) || (state_d == ST_WAIT_BUSY);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            uart_en_q <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            uart_en_q <= uart_en_d;
            tx_err_q  <= tx_err_d;
        end
    end

    // uart_din is the FIFO read register: it only changes on a pop, which
    // only happens in IDLE, so it is steady whenever uart_en is high.
    assign bus.uart_din   = fifo_rd_data;
    assign bus.uart_en    = uart_en_q;
    assign bus.tx_err     = tx_err_q;
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_cnt   = fifo_cnt;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf with a behavioural transmitter model.
module tb_uart_tx_buf;

    localparam int DEPTH   = 16;
    localparam int BUSY_TO = 8;

    logic clk = 1'b0;
    logic sys_rst;
    always #5 clk = ~clk;

    uart_tx_buf_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_buf #(
        .DEPTH   (DEPTH),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model controls (written by the stimulus block only).
    logic force_busy = 1'b0;
    logic tx_silent  = 1'b0;
    int   tx_dly     = 2;
    int   tx_hold    = 20;

    // Transmitter model state (written by the monitor only).
    logic       model_busy = 1'b0;
    logic       en_prev    = 1'b0;
    logic [7:0] din_cap    = 8'd0;
    int         dly_ctr    = 0;
    int         hold_ctr   = 0;
    int         din_changes = 0;
    int         sent_q[$];
    int         rise_cyc[$];
    int         err_cyc[$];

    assign bus.uart_tx_busy = force_busy | model_busy;

    // Transmitter: logs each send request on the uart_en rising edge,
    // raises busy tx_dly cycles later and holds it tx_hold cycles.
    always @(negedge clk) begin
        if (bus.tx_err) err_cyc.push_back(cyc);
        if (sys_rst) begin
            model_busy = 1'b0;
            dly_ctr    = 0;
            hold_ctr   = 0;
            en_prev    = 1'b0;
        end else begin
            if (bus.uart_en && !en_prev) begin
                sent_q.push_back(int'(bus.uart_din));
                rise_cyc.push_back(cyc);
                din_cap = bus.uart_din;
                if (!tx_silent) dly_ctr = tx_dly;
            end else begin
                if (bus.uart_en && bus.uart_din !== din_cap) din_changes++;
                if (dly_ctr > 0) begin
                    dly_ctr--;
                    if (dly_ctr == 0) begin
                        model_busy = 1'b1;
                        hold_ctr   = tx_hold;
                    end
                end else if (hold_ctr > 0) begin
                    hold_ctr--;
                    if (hold_ctr == 0) model_busy = 1'b0;
                end
            end
            en_prev = bus.uart_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sent_at(input int k);
        return (k < sent_q.size()) ? sent_q[k] : -1;
    endfunction

    function automatic int rise_at(input int k);
        return (k < rise_cyc.size()) ? rise_cyc[k] : -1000;
    endfunction

    function automatic int err_at(input int k);
        return (k < err_cyc.size()) ? err_cyc[k] : -1000;
    endfunction

    task automatic wr_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Wait until n_total bytes have been requested and everything is idle.
    task automatic wait_done(input int n_total, input int limit, input string tag);
        int i = 0;
        while (!(sent_q.size() >= n_total && bus.fifo_empty && !bus.uart_en &&
                 !bus.uart_tx_busy && dly_ctr == 0) && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(i < limit), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cnt"},   32'(bus.fifo_cnt),   0);
        chk({tag, "_empty"}, 32'(bus.fifo_empty), 1);
        chk({tag, "_full"},  32'(bus.fifo_full),  0);
        chk({tag, "_en"},    32'(bus.uart_en),    0);
        chk({tag, "_din"},   32'(bus.uart_din),   0);
        chk({tag, "_err"},   32'(bus.tx_err),     0);
    endtask

    initial begin
        int n0, e0, w, i, len;
        logic en_seen;
        int exp_q[$];
        logic [7:0] b;

        sys_rst     = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        sys_rst = 1'b0;
        @(negedge clk);

        // Single byte, transmitter busy 2 cycles after request, long frame.
        tx_dly  = 2;
        tx_hold = 5208;
        n0 = sent_q.size();
        e0 = err_cyc.size();
        w  = cyc;
        wr_byte(8'h55);
        i = 0;
        while (sent_q.size() == n0 && i < 10) begin
            @(negedge clk);
            i++;
        end
        chk("single_latency", 32'(rise_at(n0) - w), 2);
        chk("single_din", 32'(sent_at(n0)), 32'h55);
        wait_done(n0 + 1, 6000, "single_done");
        $display("txn single byte=55 rises=%0d", sent_q.size() - n0);
        chk("single_pulses", 32'(sent_q.size() - n0), 1);
        chk("single_empty", 32'(bus.fifo_empty), 1);
        chk("single_no_err", 32'(err_cyc.size() - e0), 0);

        // Fill while transmitter held busy, overflow write, then write+pop at full.
        tx_hold    = 20;
        force_busy = 1'b1;
        @(negedge clk);
        n0 = sent_q.size();
        en_seen = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            wr_byte(8'(k));
            en_seen |= bus.uart_en;
        end
        chk("fill_cnt", 32'(bus.fifo_cnt), DEPTH);
        chk("fill_full", 32'(bus.fifo_full), 1);
        chk("fill_empty", 32'(bus.fifo_empty), 0);
        wr_byte(8'hFF);
        chk("overflow_cnt", 32'(bus.fifo_cnt), DEPTH);
        chk("overflow_full", 32'(bus.fifo_full), 1);
        repeat (20) begin
            @(negedge clk);
            en_seen |= bus.uart_en;
        end
        chk("busy_hold_no_en", 32'(en_seen), 0);
        force_busy  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        chk("wrpop_full_cnt", 32'(bus.fifo_cnt), DEPTH);
        chk("wrpop_full_flag", 32'(bus.fifo_full), 1);
        wait_done(n0 + DEPTH + 1, 2000, "burst_done");
        chk("burst_count", 32'(sent_q.size() - n0), DEPTH + 1);
        for (int k = 0; k <= DEPTH; k++) begin
            $display("txn burst idx=%0d byte=%0h", k, sent_at(n0 + k));
            chk("burst_order", 32'(sent_at(n0 + k)), (k < DEPTH) ? 32'(k + 1) : 32'hA5);
        end

        // Transmitter never goes busy: each byte aborted BUSY_TO cycles after request.
        tx_silent = 1'b1;
        n0 = sent_q.size();
        e0 = err_cyc.size();
        wr_byte(8'h3C);
        wr_byte(8'hC3);
        wait_done(n0 + 2, 200, "timeout_done");
        $display("txn timeout errs=%0d", err_cyc.size() - e0);
        chk("timeout_err_cnt", 32'(err_cyc.size() - e0), 2);
        chk("timeout_delay0", 32'(err_at(e0) - rise_at(n0)), BUSY_TO);
        chk("timeout_delay1", 32'(err_at(e0 + 1) - rise_at(n0 + 1)), BUSY_TO);
        chk("timeout_next_after", 32'(rise_at(n0 + 1) > err_at(e0)), 1);
        chk("timeout_byte0", 32'(sent_at(n0)), 32'h3C);
        chk("timeout_byte1", 32'(sent_at(n0 + 1)), 32'hC3);
        tx_silent = 1'b0;

        // Randomized bursts with random transmitter timing and write gaps.
        e0 = err_cyc.size();
        for (int r = 0; r < 4; r++) begin
            tx_dly  = $urandom_range(1, BUSY_TO - 1);
            tx_hold = $urandom_range(1, 25);
            len     = $urandom_range(1, DEPTH);
            n0      = sent_q.size();
            exp_q.delete();
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                exp_q.push_back(int'(b));
                wr_byte(b);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_done(n0 + len, len * 60 + 100, "rand_done");
            chk("rand_count", 32'(sent_q.size() - n0), 32'(len));
            for (int k = 0; k < len; k++) begin
                $display("txn rand round=%0d idx=%0d byte=%0h exp=%0h", r, k, sent_at(n0 + k), exp_q[k]);
                chk("rand_order", 32'(sent_at(n0 + k)), 32'(exp_q[k]));
            end
        end
        chk("rand_no_err", 32'(err_cyc.size() - e0), 0);

        // Reset while the first byte is in flight and five more are queued.
        tx_dly  = 2;
        tx_hold = 300;
        n0 = sent_q.size();
        e0 = err_cyc.size();
        for (int k = 0; k < 6; k++) wr_byte(8'(8'hA0 + k));
        i = 0;
        while (!(sent_q.size() > n0 && !bus.uart_en && bus.uart_tx_busy) && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("rst_reach_wait_done", 32'(i < 50), 1);
        chk("rst_pre_cnt", 32'(bus.fifo_cnt), 5);
        sys_rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (20) @(negedge clk);
        $display("txn midreset sent=%0d errs=%0d", sent_q.size() - n0, err_cyc.size() - e0);
        chk("midrst_no_err", 32'(err_cyc.size() - e0), 0);
        chk("midrst_no_resend", 32'(sent_q.size() - n0), 1);
        chk("midrst_cnt", 32'(bus.fifo_cnt), 0);

        chk("din_stable", 32'(din_changes), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
